// File: rtl/uart_rx_pkg.sv
// Shared entry layout and constants for the UART receive error-tracking FIFO.
package uart_rx_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 16;
  localparam int STATS_W    = 16;

  typedef struct packed {
    logic                  frame_err;
    logic                  parity_err;
    logic [DEF_DATA_W-1:0] data;
  } rx_entry_t;

  localparam int FLAG_W = $bits(rx_entry_t) - DEF_DATA_W;
endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Entry storage: one write port, one registered read port, contents never reset.
module uart_rx_fifo_mem #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/uart_rx_err_fifo.sv
// UART receive FIFO with per-entry error flags and first-error address capture.
// Define UART_RX_ERR_STATS_EN to add saturating parity/frame error counters.
module uart_rx_err_fifo
  import uart_rx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_parity_err,
  input  logic              wr_frame_err,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_parity_err,
  output logic              rd_frame_err,
  output logic              rd_valid,
  input  logic              flush,
  input  logic              err_clr,
  input  logic [AW:0]       thr_level,
  output logic              empty,
  output logic              full,
  output logic              thr_hit,
  output logic              overflow,
  output logic              err_pending,
  output logic [AW:0]       level,
  output logic [AW-1:0]     err_addr
`ifdef UART_RX_ERR_STATS_EN
  ,
  output logic [STATS_W-1:0] parity_cnt,
  output logic [STATS_W-1:0] frame_cnt
`endif
);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef struct packed {
    logic              frame_err;
    logic              parity_err;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [AW-1:0] wptr, rptr, rd_addr_p1;
  logic [LW-1:0] level_next;
  logic          push_ok, pop_ok, rd_loaded, err_hit;
  entry_t        wr_entry, rd_entry;

  assign push_ok    = wr_en && !full;
  assign pop_ok     = rd_en && !empty;
  assign level_next = level + LW'(push_ok) - LW'(pop_ok);
  assign wr_entry   = '{frame_err: wr_frame_err, parity_err: wr_parity_err, data: wr_data};

  uart_rx_fifo_mem #(
    .WIDTH(DATA_W + FLAG_W),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (push_ok && !flush),
    .waddr(wptr),
    .wdata(wr_entry),
    .re   (pop_ok && !flush),
    .raddr(rptr),
    .rdata(rd_entry)
  );

  // The read register has no reset, so outputs stay zero until the first pop lands.
  assign rd_data       = rd_loaded ? rd_entry.data : '0;
  assign rd_parity_err = rd_loaded && rd_entry.parity_err;
  assign rd_frame_err  = rd_loaded && rd_entry.frame_err;
  assign thr_hit       = (thr_level != '0) && (level >= thr_level);
  assign err_hit       = rd_valid && (rd_entry.parity_err || rd_entry.frame_err);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr        <= '0;
      rptr        <= '0;
      rd_addr_p1  <= '0;
      level       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      overflow    <= 1'b0;
      rd_valid    <= 1'b0;
      rd_loaded   <= 1'b0;
      err_pending <= 1'b0;
      err_addr    <= '0;
    end else if (flush) begin
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      overflow    <= 1'b0;
      rd_valid    <= 1'b0;
      err_pending <= 1'b0;
      err_addr    <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok) begin
        rptr       <= rptr + AW'(1);
        rd_addr_p1 <= rptr;
        rd_loaded  <= 1'b1;
      end
      level    <= level_next;
      empty    <= (level_next == '0);
      full     <= (level_next == DEPTH_L);
      rd_valid <= pop_ok;
      if (wr_en && full) overflow <= 1'b1;
      // Error flags arrive with the read data; an errored pop beats a same-cycle clear.
      if (err_hit && (!err_pending || err_clr)) begin
        err_pending <= 1'b1;
        err_addr    <= rd_addr_p1;
      end else if (err_clr) begin
        err_pending <= 1'b0;
        err_addr    <= '0;
      end
    end
  end

`ifdef UART_RX_ERR_STATS_EN
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == '1) ? v : v + STATS_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_cnt <= '0;
      frame_cnt  <= '0;
    end else if (flush || err_clr) begin
      parity_cnt <= '0;
      frame_cnt  <= '0;
    end else if (rd_valid) begin
      if (rd_entry.parity_err) parity_cnt <= sat_inc(parity_cnt);
      if (rd_entry.frame_err)  frame_cnt  <= sat_inc(frame_cnt);
    end
  end
`endif
endmodule

// File: tb/tb_uart_rx_err_fifo.sv
// Directed bench for uart_rx_err_fifo at DATA_W=32, DEPTH=16.
module tb_uart_rx_err_fifo;
  localparam int DATA_W = 32;
  localparam int AW     = 4;

  logic              clk = 1'b0;
  logic              reset, wr_en, wr_parity_err, wr_frame_err, rd_en, flush, err_clr;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic              rd_parity_err, rd_frame_err, rd_valid;
  logic              empty, full, thr_hit, overflow, err_pending;
  logic [AW:0]       thr_level, level;
  logic [AW-1:0]     err_addr;
`ifdef UART_RX_ERR_STATS_EN
  logic [15:0]       parity_cnt, frame_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_rx_err_fifo #(.DATA_W(DATA_W), .DEPTH(16)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_data(wr_data), .wr_parity_err(wr_parity_err), .wr_frame_err(wr_frame_err),
    .rd_en(rd_en), .rd_data(rd_data), .rd_parity_err(rd_parity_err), .rd_frame_err(rd_frame_err),
    .rd_valid(rd_valid), .flush(flush), .err_clr(err_clr), .thr_level(thr_level),
    .empty(empty), .full(full), .thr_hit(thr_hit), .overflow(overflow),
    .err_pending(err_pending), .level(level), .err_addr(err_addr)
`ifdef UART_RX_ERR_STATS_EN
    , .parity_cnt(parity_cnt), .frame_cnt(frame_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic pe, input logic fe);
    wr_en = 1'b1; wr_data = d; wr_parity_err = pe; wr_frame_err = fe;
    tick();
    wr_en = 1'b0; wr_parity_err = 1'b0; wr_frame_err = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; wr_parity_err = 1'b0; wr_frame_err = 1'b0;
    rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0; thr_level = '0;
    tick(); tick();
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_full", full, 1'b0);
    chkw("rst_level", 64'(level), 64'd0);
    chk1("rst_rd_valid", rd_valid, 1'b0);
    chk1("rst_overflow", overflow, 1'b0);
    chk1("rst_err_pending", err_pending, 1'b0);
    chkw("rst_rd_data", 64'(rd_data), 64'd0);
    reset = 1'b0;

    // Fill with 0..15, then drain in order.
    for (int i = 0; i < 16; i++) begin
      push(DATA_W'(i), 1'b0, 1'b0);
      chkw("fill_level", 64'(level), 64'(i + 1));
    end
    chk1("fill_full", full, 1'b1);
    chk1("fill_empty", empty, 1'b0);
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk1("drain_rd_valid", rd_valid, 1'b1);
      chkw("drain_rd_data", 64'(rd_data), 64'(i));
    end
    rd_en = 1'b0;
    chk1("drain_empty", empty, 1'b1);
    chk1("drain_full", full, 1'b0);
    tick();
    chk1("idle_rd_valid", rd_valid, 1'b0);
    chkw("idle_rd_data_hold", 64'(rd_data), 64'hF);

    // Push against a full FIFO with a simultaneous pop.
    for (int i = 0; i < 16; i++) push(DATA_W'(32'h100 + i), 1'b0, 1'b0);
    chk1("ovf_full", full, 1'b1);
    wr_en = 1'b1; wr_data = 32'hAA; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk1("ovf_overflow", overflow, 1'b1);
    chkw("ovf_level", 64'(level), 64'd15);
    chkw("ovf_rd_data", 64'(rd_data), 64'h100);
    rd_en = 1'b1;
    repeat (15) tick();
    rd_en = 1'b0;
    chkw("ovf_last_data", 64'(rd_data), 64'h10F);
    chk1("ovf_drained_empty", empty, 1'b1);
    chk1("ovf_sticky", overflow, 1'b1);
    do_flush();
    chk1("ovf_flush_clear", overflow, 1'b0);

    // Threshold.
    thr_level = 5'd13;
    for (int i = 0; i < 12; i++) push(DATA_W'(i), 1'b0, 1'b0);
    chk1("thr_below", thr_hit, 1'b0);
    push(32'hC, 1'b0, 1'b0);
    chk1("thr_hit13", thr_hit, 1'b1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk1("thr_after_pop", thr_hit, 1'b0);
    thr_level = 5'd0; #1;
    chk1("thr_zero", thr_hit, 1'b0);
    for (int i = 0; i < 4; i++) push(DATA_W'(i), 1'b0, 1'b0);
    chk1("thr_full", full, 1'b1);
    thr_level = 5'd17; #1;
    chk1("thr_above_depth", thr_hit, 1'b0);
    thr_level = 5'd16; #1;
    chk1("thr_eq_depth", thr_hit, 1'b1);
    thr_level = 5'd0;
    do_flush();

    // First-error capture.
    for (int i = 0; i < 8; i++) push(DATA_W'(32'h300 + i), (i == 2 || i == 5), 1'b0);
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 2) chk1("err_rd_parity_slot2", rd_parity_err, 1'b1);
    end
    rd_en = 1'b0;
    tick();
    chk1("err_pending", err_pending, 1'b1);
    chkw("err_addr_first", 64'(err_addr), 64'd2);
    push(32'h3FF, 1'b0, 1'b1);
    rd_en = 1'b1; err_clr = 1'b1;
    tick();
    rd_en = 1'b0; err_clr = 1'b0;
    chk1("err_rd_frame", rd_frame_err, 1'b1);
    tick();
    chk1("err_clr_race_pending", err_pending, 1'b1);
    chkw("err_clr_race_addr", 64'(err_addr), 64'd8);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk1("err_clr_pending", err_pending, 1'b0);
    chkw("err_clr_addr", 64'(err_addr), 64'd0);
    do_flush();

    // Flush overriding push and pop.
    for (int i = 0; i < 8; i++) push(DATA_W'(32'h400 + i), 1'b0, 1'b0);
    wr_en = 1'b1; wr_data = 32'h4FF; rd_en = 1'b1; flush = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    chkw("flush_level", 64'(level), 64'd0);
    chk1("flush_empty", empty, 1'b1);
    chk1("flush_rd_valid", rd_valid, 1'b0);
    chkw("flush_rd_data_hold", 64'(rd_data), 64'h3FF);
    push(32'h55, 1'b0, 1'b0);
    chkw("post_flush_level", 64'(level), 64'd1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chkw("post_flush_data", 64'(rd_data), 64'h55);

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 16; i++) push(DATA_W'(32'h200 + i), (i == 0), 1'b0);
    wr_en = 1'b1; wr_data = 32'h2AA;
    tick();
    rd_en = 1'b1;
    tick(); tick();
    chk1("pre_rst_overflow", overflow, 1'b1);
    chk1("pre_rst_err_pending", err_pending, 1'b1);
    chkw("pre_rst_rd_data", 64'(rd_data), 64'h201);
    #3 reset = 1'b1;
    #1;
    chk1("mid_rst_empty", empty, 1'b1);
    chk1("mid_rst_full", full, 1'b0);
    chkw("mid_rst_level", 64'(level), 64'd0);
    chk1("mid_rst_overflow", overflow, 1'b0);
    chk1("mid_rst_err_pending", err_pending, 1'b0);
    chk1("mid_rst_rd_valid", rd_valid, 1'b0);
    chkw("mid_rst_rd_data", 64'(rd_data), 64'd0);
    chk1("mid_rst_rd_parity", rd_parity_err, 1'b0);
    chk1("mid_rst_thr_hit", thr_hit, 1'b0);
    rd_en = 1'b0; wr_data = 32'h77;
    @(posedge clk);
    #4 reset = 1'b0;
    tick();
    wr_en = 1'b0;
    chkw("rel_first_push_level", 64'(level), 64'd1);
    chk1("rel_first_push_empty", empty, 1'b0);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chkw("rel_pop_data", 64'(rd_data), 64'h77);

`ifdef UART_RX_ERR_STATS_EN
    for (int i = 0; i < 3; i++) push(DATA_W'(32'h500 + i), 1'b1, 1'b0);
    push(32'h503, 1'b0, 1'b1);
    push(32'h504, 1'b0, 1'b0);
    rd_en = 1'b1;
    repeat (5) tick();
    rd_en = 1'b0;
    tick();
    chkw("stats_parity_cnt", 64'(parity_cnt), 64'd3);
    chkw("stats_frame_cnt", 64'(frame_cnt), 64'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chkw("stats_clr_parity", 64'(parity_cnt), 64'd0);
    chkw("stats_clr_frame", 64'(frame_cnt), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx_err_fifo.md
UART_RX_ERR_FIFO -- requirements
Module: uart_rx_err_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning payload width in bits (1..64).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning entry count (power of 2, 4..256); AW = log2(DEPTH).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-005 The block SHALL have ports wr_en/wr_data/wr_parity_err/wr_frame_err, inputs, 1/DATA_W/1/1, meaning the push request and the entry contents.
REQ-006 The block SHALL have port rd_en, input, 1, meaning pop request.
REQ-007 The block SHALL have ports rd_data/rd_parity_err/rd_frame_err/rd_valid, outputs, DATA_W/1/1/1, meaning the popped entry and its valid strobe.
REQ-008 The block SHALL have ports flush, input, 1, meaning synchronous clear; err_clr, input, 1, meaning error-capture clear; thr_level, input, AW+1, meaning the programmable threshold.
REQ-009 The block SHALL have outputs empty, full, thr_hit, overflow, err_pending (1 bit each), level (AW+1), and err_addr (AW).

Function
REQ-010 A push SHALL be accepted when wr_en=1 and full=0; the entry is stored at wptr, and wptr increments modulo DEPTH.
REQ-011 A pop SHALL be accepted when rd_en=1 and empty=0; rptr increments modulo DEPTH.
REQ-012 rd_data/rd_parity_err/rd_frame_err SHALL be registered and SHALL update, together with a one-cycle rd_valid pulse, in the cycle after an accepted pop; otherwise they hold their value.
REQ-013 level SHALL equal stored entries: +1 on push only, -1 on pop only, unchanged on a simultaneous push and pop.
REQ-014 When full=1, a push SHALL be rejected even if a pop is accepted in the same cycle.
REQ-015 When empty=1, a simultaneous push and pop SHALL accept the push only.
REQ-016 empty SHALL be (level==0), full SHALL be (level==DEPTH), both registered, with no combinational input-to-flag path.
REQ-017 thr_hit SHALL be (thr_level!=0 && level>=thr_level); thr_level>DEPTH SHALL never assert thr_hit.
REQ-018 overflow SHALL set sticky on a rejected push and SHALL clear only on flush or reset.
REQ-019 On an accepted pop whose entry has a parity or frame error, with err_pending=0, the block SHALL set err_pending and capture err_addr=rptr (first-error capture).
REQ-020 While err_pending=1, later errored pops SHALL NOT change err_addr.
REQ-021 err_clr SHALL clear err_pending and err_addr to 0; an errored pop in the same cycle SHALL win and capture the new address.
REQ-022 flush SHALL, in one cycle, zero wptr, rptr, level, overflow, err_pending and err_addr; it SHALL override a push or pop in that cycle; memory contents need not clear.

Reset
REQ-023 Reset SHALL asynchronously force pointers and level to 0, empty=1, all other outputs to 0, and counters to 0; memory is not reset.
REQ-024 Reset deassertion mid-traffic SHALL yield an empty FIFO with the first push accepted on the first clk edge after release.

Configuration
REQ-025 With UART_RX_ERR_STATS_EN defined, the block SHALL add outputs parity_cnt and frame_cnt (16 bits each), saturating counts of errored entries popped, cleared by reset, flush and err_clr.
REQ-026 Without UART_RX_ERR_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-027 Package uart_rx_pkg SHALL hold the rx_entry_t struct {frame_err, parity_err, data[DATA_W]} width constants and the STATS_W=16 constant.
REQ-028 Storage SHALL be sub-module uart_rx_fifo_mem (1 write port, 1 registered read port, no reset); pointer, flag and error logic SHALL stay in the top.

Verification
REQ-029 Write 16 words 0x0..0xF at DEPTH=16, then pop all -> data in order, full=1 after the 16th push, empty=1 after the last pop, rd_valid 1 cycle after each pop.
REQ-030 Fill to full, then push 0xAA with a simultaneous pop -> push rejected, overflow=1, level=15.
REQ-031 thr_level=13; push 13 words -> thr_hit rises on the 13th and falls after one pop; thr_level=0 -> thr_hit stays 0.
REQ-032 Push entries at slots 2 and 5 with parity_err=1, then pop all -> err_pending=1 and err_addr=2; err_clr -> 0.
REQ-033 Push 8 words and assert flush together with wr_en/rd_en -> level=0, empty=1, no rd_valid; assert reset mid-burst -> all outputs at reset values.
REQ-034 With UART_RX_ERR_STATS_EN, pop 3 parity-errored and 1 frame-errored entries -> parity_cnt=3 and frame_cnt=1.
